// File: rtl/tb_dmem_pkg.sv
// Shared types and constants for the testbench data memory / HTIF watcher.
package tb_dmem_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } status_e;

  localparam logic [31:0] TIMEOUT_CODE = 32'hFFFF_FFFF;
  localparam logic [31:0] HTIF_PASS    = 32'd1;

  // Galois LFSR, right-shifting, taps 16,14,13,11
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/tb_dmem_htif_if.sv
// CPU dmem request/response bus between the core (master) and the memory model (slave).
interface tb_dmem_htif_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W/8-1:0]   req_be;
  logic [DATA_W-1:0]     req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_W-1:0]     resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );

endinterface

// File: rtl/tb_dmem_htif_fifo.sv
// Synchronous FIFO with valid/ready on both sides; output data reads 0 while empty.
module tb_resp_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop;

  // Handshakes and flags
  always_comb begin
    in_ready  = (count != CNT_W'(DEPTH));
    out_valid = (count != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    out_data  = out_valid ? store[rd_ptr] : '0;
  end

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= in_data;
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tb_dmem_htif.sv
// Testbench data memory with HTIF tohost watcher: byte-strobed stores, fixed-latency
// in-order loads with a bounded outstanding window, and a pass/fail/timeout status FSM.
// Optional macro TB_DMEM_RAND_STALL_EN: LFSR-driven random req_ready stalls.
module tb_dmem_htif
  import tb_dmem_pkg::*;
#(
  parameter int unsigned       DATA_W          = 32,
  parameter int unsigned       ADDR_W          = 32,
  parameter int unsigned       MEM_SIZE_WORDS  = 16384,
  parameter logic [ADDR_W-1:0] MEM_BASE        = '0,
  parameter int unsigned       LOAD_LATENCY    = 1,
  parameter int unsigned       MAX_OUTSTANDING = 4,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR     = ADDR_W'(32'h0000_1000),
  parameter int unsigned       TIMEOUT_CYCLES  = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  tb_dmem_htif_if.slave bus,
  output logic        test_done,
  output logic        test_pass,
  output logic [31:0] test_code,
  output logic        addr_err,
  output logic [31:0] cycle_count
);

  localparam int unsigned BE_W    = DATA_W / 8;
  localparam int unsigned BYTE_SH = $clog2(BE_W);
  localparam int unsigned IDX_W   = (MEM_SIZE_WORDS > 1) ? $clog2(MEM_SIZE_WORDS) : 1;
  localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING + 1);

  logic [DATA_W-1:0] mem [MEM_SIZE_WORDS];

  logic [ADDR_W-1:0] offset, word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic              in_range;
  logic              req_fire, st_fire, ld_fire, resp_fire;
  logic [DATA_W-1:0] rd_word;
  logic              stall;

  logic [CNT_W-1:0]        inflight;
  logic [LOAD_LATENCY-1:0] pipe_v;
  logic [DATA_W-1:0]       pipe_d [LOAD_LATENCY];
  logic                    fifo_in_ready;

  status_e     state_q, state_d;
  logic [31:0] code_q, code_d;
  logic [31:0] tohost_val;
  logic        tohost_fire, timeout_hit;

  // Address decode and handshake qualification
  always_comb begin
    offset    = bus.req_addr - MEM_BASE;
    word_idx  = offset >> BYTE_SH;
    in_range  = (word_idx < ADDR_W'(MEM_SIZE_WORDS));
    mem_idx   = word_idx[IDX_W-1:0];
    req_fire  = bus.req_valid && bus.req_ready;
    st_fire   = req_fire && bus.req_we;
    ld_fire   = req_fire && !bus.req_we;
    resp_fire = bus.resp_valid && bus.resp_ready;
    rd_word   = in_range ? mem[mem_idx] : '0;
  end

  // Byte-strobed store; out-of-range stores are dropped, contents survive reset
  always_ff @(posedge clk) begin
    if (rst_n && st_fire && in_range) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (bus.req_be[b]) mem[mem_idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
      end
    end
  end

`ifdef TB_DMEM_RAND_STALL_EN
  logic [15:0] lfsr;

  // Free-running stall pattern generator
  always_ff @(posedge clk) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= lfsr_next(lfsr);
  end

  // Close the accept window on one LFSR state in four
  always_comb stall = (lfsr[1:0] == 2'b00);
`else
  // No random stalls in the default build
  always_comb stall = 1'b0;
`endif

  // Accept window bounded by loads not yet returned
  always_comb bus.req_ready = (inflight < CNT_W'(MAX_OUTSTANDING)) && !stall;

  // In-flight load count: accepted but not yet consumed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({ld_fire, resp_fire})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Load latency valid pipeline; never stalls because the window bounds FIFO fill
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= ld_fire;
      for (int unsigned i = 1; i < LOAD_LATENCY; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  // Load latency data pipeline, memory sampled at the accepting edge
  always_ff @(posedge clk) begin
    pipe_d[0] <= rd_word;
    for (int unsigned i = 1; i < LOAD_LATENCY; i++) pipe_d[i] <= pipe_d[i-1];
  end

  tb_resp_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (pipe_v[LOAD_LATENCY-1] && fifo_in_ready),
    .in_ready  (fifo_in_ready),
    .in_data   (pipe_d[LOAD_LATENCY-1]),
    .out_valid (bus.resp_valid),
    .out_ready (bus.resp_ready),
    .out_data  (bus.resp_rdata)
  );

  // Sticky out-of-range access flag
  always_ff @(posedge clk) begin
    if (!rst_n)                     addr_err <= 1'b0;
    else if (req_fire && !in_range) addr_err <= 1'b1;
  end

  // Cycle counter runs only while the test is still in progress
  always_ff @(posedge clk) begin
    if (!rst_n)                 cycle_count <= '0;
    else if (state_q == ST_RUN) cycle_count <= cycle_count + 32'd1;
  end

  always_comb begin
    tohost_val  = bus.req_wdata[31:0];
    tohost_fire = st_fire && (bus.req_addr == TOHOST_ADDR);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_count == 32'(TIMEOUT_CYCLES - 1));
  end

  // Status state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  // Status next state: odd tohost value ends the test and beats a same-cycle timeout
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    if (state_q == ST_RUN) begin
      if (tohost_fire && (tohost_val == HTIF_PASS)) begin
        state_d = ST_PASS;
      end else if (tohost_fire && tohost_val[0]) begin
        state_d = ST_FAIL;
        code_d  = {1'b0, tohost_val[31:1]};
      end else if (timeout_hit) begin
        state_d = ST_TIMEOUT;
      end
    end
  end

  // Status outputs
  always_comb begin
    test_done = (state_q != ST_RUN);
    test_pass = (state_q == ST_PASS);
    case (state_q)
      ST_FAIL:    test_code = code_q;
      ST_TIMEOUT: test_code = TIMEOUT_CODE;
      default:    test_code = '0;
    endcase
  end

endmodule

// File: tb/tb_tb_dmem_htif.sv
// Self-checking bench for tb_dmem_htif: directed scenarios plus randomized traffic
// checked against a transaction-level memory/status model.
module tb_tb_dmem_htif;

  localparam int          L      = 3;
  localparam int          MAXO   = 4;
  localparam int          TMO    = 50;
  localparam int          WORDS  = 16384;
  localparam logic [31:0] TOHOST = 32'h0000_1000;
  localparam int S_RUN = 0, S_PASS = 1, S_FAIL = 2, S_TMO = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        test_done, test_pass, addr_err;
  logic [31:0] test_code, cycle_count;

  always #5 clk = ~clk;

  tb_dmem_htif_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  tb_dmem_htif #(
    .DATA_W          (32),
    .ADDR_W          (32),
    .MEM_SIZE_WORDS  (WORDS),
    .MEM_BASE        (32'h0),
    .LOAD_LATENCY    (L),
    .MAX_OUTSTANDING (MAXO),
    .TOHOST_ADDR     (TOHOST),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .test_done   (test_done),
    .test_pass   (test_pass),
    .test_code   (test_code),
    .addr_err    (addr_err),
    .cycle_count (cycle_count)
  );

  typedef struct {
    logic [31:0] d;
    int          rdy;
  } exp_t;

  bit [31:0]   mref [WORDS];
  exp_t        q[$];
  int          m_state;
  int unsigned m_cyc;
  logic [31:0] m_code;
  bit          m_aerr;
  int          tnow = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic idle();
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_be = '0; bus.req_wdata = '0;
  endtask

  task automatic drive(input bit we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_be = be; bus.req_wdata = d;
  endtask

  // One clock edge: apply spec rules to the model for whatever fires at this edge
  task automatic tick(output bit rf, output logic [31:0] got, output logic [31:0] exp, output bit rqf);
    bit          reqf, inr, run_before;
    int unsigned w;
    logic [31:0] v;
    exp_t        e;
    reqf = bus.req_valid && bus.req_ready;
    rf   = bus.resp_valid && bus.resp_ready;
    got  = bus.resp_rdata;
    exp  = 32'hx;
    run_before = (m_state == S_RUN);
    if (rf && q.size() > 0) begin exp = q[0].d; void'(q.pop_front()); end
    if (reqf) begin
      w   = bus.req_addr >> 2;
      inr = (w < WORDS);
      if (!inr) m_aerr = 1'b1;
      if (bus.req_we) begin
        if (inr) for (int b = 0; b < 4; b++) if (bus.req_be[b]) mref[w][8*b +: 8] = bus.req_wdata[8*b +: 8];
        if (bus.req_addr == TOHOST && m_state == S_RUN) begin
          v = bus.req_wdata;
          if (v == 32'd1) begin m_state = S_PASS; m_code = 32'd0; end
          else if (v[0]) begin m_state = S_FAIL; m_code = v >> 1; end
        end
      end else begin
        e.d = inr ? 32'(mref[w]) : 32'd0;
        e.rdy = tnow + 1 + L;
        q.push_back(e);
      end
    end
    if (run_before) begin
      if (m_state == S_RUN && m_cyc == TMO - 1) begin m_state = S_TMO; m_code = 32'hFFFF_FFFF; end
      m_cyc++;
    end
    @(posedge clk); #1;
    tnow++;
    rqf = reqf;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; idle(); bus.resp_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    tnow += 2;
    q.delete(); m_state = S_RUN; m_cyc = 0; m_code = 0; m_aerr = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic issue(input bit we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    bit rf, rqf, done;
    logic [31:0] g, e;
    done = 1'b0;
    drive(we, a, be, d);
    for (int i = 0; i < 20 && !done; i++) begin tick(rf, g, e, rqf); done = rqf; end
    idle();
    if (!done) begin n_checks++; n_fail++; $display("FAIL issue_timeout: addr %h not accepted in 20 cycles, required acceptance", a); end
  endtask

  task automatic wait_resp(output logic [31:0] got, output logic [31:0] exp);
    bit rf, rqf, done;
    logic [31:0] g, e;
    done = 1'b0; got = 32'hx; exp = 32'hx;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 30 && !done; i++) begin
      tick(rf, g, e, rqf);
      if (rf) begin done = 1'b1; got = g; exp = e; end
    end
    if (!done) begin n_checks++; n_fail++; $display("FAIL resp_timeout: no response in 30 cycles, required one"); end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b required 1", bus.req_ready); end
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b required 0", bus.resp_valid); end
    n_checks++; if (bus.resp_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_resp_rdata: got %h required 0", bus.resp_rdata); end
    n_checks++; if (test_done !== 1'b0) begin n_fail++; $display("FAIL rst_test_done: got %b required 0", test_done); end
    n_checks++; if (test_pass !== 1'b0) begin n_fail++; $display("FAIL rst_test_pass: got %b required 0", test_pass); end
    n_checks++; if (test_code !== 32'd0) begin n_fail++; $display("FAIL rst_test_code: got %h required 0", test_code); end
    n_checks++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL rst_addr_err: got %b required 0", addr_err); end
    n_checks++; if (cycle_count !== 32'd0) begin n_fail++; $display("FAIL rst_cycle_count: got %0d required 0", cycle_count); end
  endtask

  task automatic test_load_latency();
    bit rf, rqf;
    logic [31:0] g, e, gotd;
    int found;
    do_reset();
    issue(1'b1, 32'h100, 4'hF, 32'hDEAD_BEEF);
    drive(1'b0, 32'h100, 4'h0, 32'h0);
    tick(rf, g, e, rqf);
    idle();
    n_checks++; if (rqf !== 1'b1) begin n_fail++; $display("FAIL lat_accept: got %b required 1", rqf); end
    found = -1; gotd = 32'hx;
    for (int k = 1; k <= 8; k++) begin
      tick(rf, g, e, rqf);
      if (bus.resp_valid && found < 0) begin found = k; gotd = bus.resp_rdata; end
    end
    n_checks++; if (found != L) begin n_fail++; $display("FAIL lat_cycles: got %0d required %0d", found, L); end
    n_checks++; if (gotd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lat_data: got %h required deadbeef", gotd); end
  endtask

  task automatic test_byte_strobe();
    logic [31:0] g, e;
    do_reset();
    issue(1'b1, 32'h200, 4'hF, 32'h1122_3344);
    issue(1'b1, 32'h200, 4'b0101, 32'hAABB_CCDD);
    issue(1'b0, 32'h200, 4'h0, 32'h0);
    wait_resp(g, e);
    n_checks++; if (g !== 32'h11BB_33DD) begin n_fail++; $display("FAIL strobe_data: got %h required 11bb33dd", g); end
  endtask

  task automatic test_backpressure();
    bit rf, rqf;
    logic [31:0] g, e;
    int issued, recv;
    do_reset();
    for (int i = 0; i < 6; i++) issue(1'b1, 32'(4*i), 4'hF, 32'(i));
    bus.resp_ready = 1'b0; issued = 0;
    for (int c = 0; c < 10; c++) begin
      if (issued < 6) drive(1'b0, 32'(4*issued), 4'h0, 32'h0); else idle();
      tick(rf, g, e, rqf);
      if (rqf) issued++;
    end
    n_checks++; if (issued != MAXO) begin n_fail++; $display("FAIL bp_accepts: got %0d required %0d", issued, MAXO); end
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready: got %b required 0", bus.req_ready); end
    n_checks++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_resp_valid: got %b required 1", bus.resp_valid); end
    bus.resp_ready = 1'b1; recv = 0;
    for (int c = 0; c < 40 && recv < 6; c++) begin
      if (issued < 6) drive(1'b0, 32'(4*issued), 4'h0, 32'h0); else idle();
      tick(rf, g, e, rqf);
      if (rqf) issued++;
      if (rf) begin
        n_checks++; if (g !== 32'(recv)) begin n_fail++; $display("FAIL bp_order: got %h required %h", g, 32'(recv)); end
        recv++;
      end
    end
    idle();
    n_checks++; if (recv != 6) begin n_fail++; $display("FAIL bp_count: got %0d required 6", recv); end
  endtask

  task automatic test_tohost_pass();
    bit rf, rqf;
    logic [31:0] g, e;
    do_reset();
    issue(1'b1, TOHOST, 4'hF, 32'd1);
    n_checks++; if (test_done !== 1'b1 || test_pass !== 1'b1) begin n_fail++; $display("FAIL pass_flags: got done=%b pass=%b required 1 1", test_done, test_pass); end
    n_checks++; if (test_code !== 32'd0) begin n_fail++; $display("FAIL pass_code: got %h required 0", test_code); end
    issue(1'b1, TOHOST, 4'hF, 32'd7);
    for (int i = 0; i < 4; i++) tick(rf, g, e, rqf);
    n_checks++; if (test_pass !== 1'b1 || test_code !== 32'd0) begin n_fail++; $display("FAIL pass_sticky: got pass=%b code=%h required 1 0", test_pass, test_code); end
    n_checks++; if (cycle_count !== m_cyc) begin n_fail++; $display("FAIL pass_frozen: got %0d required %0d", cycle_count, m_cyc); end
    issue(1'b0, TOHOST, 4'h0, 32'h0);
    wait_resp(g, e);
    n_checks++; if (g !== 32'd7) begin n_fail++; $display("FAIL pass_memwrite: got %h required 7", g); end
  endtask

  task automatic test_tohost_fail();
    do_reset();
    issue(1'b1, TOHOST, 4'hF, 32'h2A);
    n_checks++; if (test_done !== 1'b0) begin n_fail++; $display("FAIL even_ignored: got done=%b required 0", test_done); end
    issue(1'b1, TOHOST, 4'hF, 32'h2B);
    n_checks++; if (test_done !== 1'b1 || test_pass !== 1'b0) begin n_fail++; $display("FAIL fail_flags: got done=%b pass=%b required 1 0", test_done, test_pass); end
    n_checks++; if (test_code !== 32'h15) begin n_fail++; $display("FAIL fail_code: got %h required 15", test_code); end
  endtask

  task automatic test_tohost_vs_timeout();
    bit rf, rqf;
    logic [31:0] g, e;
    do_reset();
    for (int i = 0; i < 100 && m_cyc < TMO - 1; i++) tick(rf, g, e, rqf);
    issue(1'b1, TOHOST, 4'hF, 32'd1);
    n_checks++; if (test_pass !== 1'b1 || test_code !== 32'd0) begin n_fail++; $display("FAIL race_pass: got pass=%b code=%h required 1 0", test_pass, test_code); end
    n_checks++; if (cycle_count !== 32'(TMO)) begin n_fail++; $display("FAIL race_cycles: got %0d required %0d", cycle_count, TMO); end
  endtask

  task automatic test_timeout_addr();
    bit rf, rqf;
    logic [31:0] g, e;
    do_reset();
    issue(1'b1, 32'h0, 4'hF, 32'h5A5A_0002);
    for (int i = 0; i < 80 && !test_done; i++) tick(rf, g, e, rqf);
    n_checks++; if (test_done !== 1'b1 || test_pass !== 1'b0) begin n_fail++; $display("FAIL tmo_flags: got done=%b pass=%b required 1 0", test_done, test_pass); end
    n_checks++; if (cycle_count !== 32'(TMO)) begin n_fail++; $display("FAIL tmo_cycles: got %0d required %0d", cycle_count, TMO); end
    n_checks++; if (test_code !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL tmo_code: got %h required ffffffff", test_code); end
    n_checks++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL aerr_clean: got %b required 0", addr_err); end
    issue(1'b1, 32'h0010_0000, 4'hF, 32'hFFFF_FFFF);
    issue(1'b0, 32'h0010_0000, 4'h0, 32'h0);
    wait_resp(g, e);
    n_checks++; if (g !== 32'd0) begin n_fail++; $display("FAIL oor_load: got %h required 0", g); end
    n_checks++; if (addr_err !== 1'b1) begin n_fail++; $display("FAIL oor_flag: got %b required 1", addr_err); end
    issue(1'b0, 32'h0, 4'h0, 32'h0);
    wait_resp(g, e);
    n_checks++; if (g !== 32'h5A5A_0002) begin n_fail++; $display("FAIL oor_store_dropped: got %h required 5a5a0002", g); end
  endtask

  task automatic test_random();
    bit rf, rqf;
    logic [31:0] g, e, a, d;
    int r;
    bit exp_rv;
    do_reset();
    for (int i = 0; i < 64; i++) issue(1'b1, 32'(4*i), 4'hF, $urandom);
    issue(1'b1, TOHOST, 4'hF, 32'd0);
    for (int c = 0; c < 200; c++) begin
      exp_rv = (q.size() > 0) && (q[0].rdy <= tnow);
      n_checks++; if (bus.req_ready !== (q.size() < MAXO)) begin n_fail++; $display("FAIL rnd_req_ready c%0d: got %b required %b", c, bus.req_ready, q.size() < MAXO); end
      n_checks++; if (bus.resp_valid !== exp_rv) begin n_fail++; $display("FAIL rnd_resp_valid c%0d: got %b required %b", c, bus.resp_valid, exp_rv); end
      if (exp_rv) begin
        n_checks++; if (bus.resp_rdata !== q[0].d) begin n_fail++; $display("FAIL rnd_rdata c%0d: got %h required %h", c, bus.resp_rdata, q[0].d); end
      end
      n_checks++; if (cycle_count !== m_cyc || test_done !== (m_state != S_RUN) || test_code !== m_code)
        begin n_fail++; $display("FAIL rnd_status c%0d: got cyc=%0d done=%b code=%h required %0d %b %h", c, cycle_count, test_done, test_code, m_cyc, m_state != S_RUN, m_code); end
      n_checks++; if (addr_err !== m_aerr) begin n_fail++; $display("FAIL rnd_addr_err c%0d: got %b required %b", c, addr_err, m_aerr); end
      r = $urandom_range(0, 15);
      d = $urandom;
      if (r <= 12)      a = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
      else if (r == 13) begin a = TOHOST; d = d & ~32'd1; end
      else if (r == 14) a = TOHOST;
      else              a = 32'h0001_0000 + 32'($urandom_range(0, 255) * 4);
      if ($urandom_range(0, 2) != 0) drive($urandom_range(0, 2) == 0, a, 4'($urandom), d); else idle();
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      tick(rf, g, e, rqf);
    end
    idle(); bus.resp_ready = 1'b1;
    for (int i = 0; i < 30 && q.size() > 0; i++) begin
      n_checks++; if (bus.resp_valid && bus.resp_rdata !== q[0].d) begin n_fail++; $display("FAIL drain_rdata: got %h required %h", bus.resp_rdata, q[0].d); end
      tick(rf, g, e, rqf);
    end
    n_checks++; if (q.size() != 0 || bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got pending=%0d resp_valid=%b required 0 0", q.size(), bus.resp_valid); end
  endtask

  initial begin
    idle();
    bus.resp_ready = 1'b1;
    m_state = S_RUN; m_cyc = 0; m_code = 0; m_aerr = 1'b0;
    test_reset();
    test_load_latency();
    test_byte_strobe();
    test_backpressure();
    test_tohost_pass();
    test_tohost_fail();
    test_tohost_vs_timeout();
    test_timeout_addr();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1);
  end

endmodule
